// File: rtl/mem_stage_ws.sv
// mem_stage_ws: E->M pipeline register, segmented data memory
// (text/data/stack) and a wait-state engine that stalls upstream.
// Ports: clk, rst_n (async, active low); E-side controls RegWriteE,
// MemtoRegE, MemWriteE, SizeE, SignedE, ALUOutE, WriteDataE, WriteRegE;
// M-side RegWriteM, MemtoRegM, ALUOutM, WriteRegM, RD (formatted load
// data), StallM (hold E inputs), MemFaultM (faulted access in M).
// Build option: define MEM_ALIGN_CHECK_EN to fault misaligned half/word.
module mem_stage_ws #(
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] TEXT_BASE   = 32'h0,
    parameter int unsigned TEXT_WORDS  = 256,
    parameter logic [31:0] DATA_BASE   = 32'h400,
    parameter int unsigned DATA_WORDS  = 1024,
    parameter logic [31:0] STACK_TOP   = 32'h7FFFFC,
    parameter int unsigned STACK_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [1:0]  SizeE,
    input  logic        SignedE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        MemFaultM
);

    localparam int TAW = (TEXT_WORDS  > 1) ? $clog2(TEXT_WORDS)  : 1;
    localparam int DAW = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
    localparam int SAW = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

    localparam logic [31:0] TEXT_SPAN  = 32'(4 * TEXT_WORDS);
    localparam logic [31:0] DATA_SPAN  = 32'(4 * DATA_WORDS);
    localparam logic [31:0] STACK_SPAN = 32'(4 * STACK_WORDS);
    localparam logic [31:0] STACK_LO   = STACK_TOP - 32'(4 * (STACK_WORDS - 1));
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    logic        r_regwrite;
    logic        r_memtoreg;
    logic        r_memwrite;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_aluout;
    logic [31:0] r_wdata;
    logic [4:0]  r_writereg;
    logic [3:0]  r_cnt;

    logic [31:0] r_text  [TEXT_WORDS];
    logic [31:0] r_data  [DATA_WORDS];
    logic [31:0] r_stack [STACK_WORDS];

    logic        w_stall;
    logic        w_access;
    logic [31:0] w_toff;
    logic [31:0] w_doff;
    logic [31:0] w_soff;
    logic        w_in_text;
    logic        w_in_data;
    logic        w_in_stack;
    logic        w_misal;
    logic        w_fault;
    logic        w_commit;
    logic [TAW-1:0] w_tidx;
    logic [DAW-1:0] w_didx;
    logic [SAW-1:0] w_sidx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic [31:0] w_merge;

    assign w_stall  = (r_cnt != 4'd0);
    assign w_access = r_memwrite | r_memtoreg;

    // Offsets wrap below the base, so one unsigned compare covers both ends.
    assign w_toff     = r_aluout - TEXT_BASE;
    assign w_doff     = r_aluout - DATA_BASE;
    assign w_soff     = r_aluout - STACK_LO;
    assign w_in_text  = (w_toff < TEXT_SPAN);
    assign w_in_data  = (w_doff < DATA_SPAN);
    assign w_in_stack = (w_soff < STACK_SPAN);
    assign w_tidx     = w_toff[TAW+1:2];
    assign w_didx     = w_doff[DAW+1:2];
    assign w_sidx     = w_soff[SAW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misal = ((r_size == 2'b01) && r_aluout[0]) ||
                     (r_size[1] && (r_aluout[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    assign w_fault  = w_access &
                      (~(w_in_text | w_in_data | w_in_stack) | w_misal);
    assign w_commit = r_memwrite & ~w_stall & ~w_fault;

    always_comb begin
        w_word = 32'h0;
        unique case (1'b1)
            w_in_text:  w_word = r_text[w_tidx];
            w_in_data:  w_word = r_data[w_didx];
            w_in_stack: w_word = r_stack[w_sidx];
            default:    w_word = 32'h0;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte/half.
    always_comb begin
        w_byte = 8'h0;
        case (r_aluout[1:0])
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
        w_half = r_aluout[1] ? w_word[15:0] : w_word[31:16];
        w_fmt  = w_word;
        case (r_size)
            2'b00: w_fmt = r_signed ? {{24{w_byte[7]}}, w_byte}
                                    : {24'h0, w_byte};
            2'b01: w_fmt = r_signed ? {{16{w_half[15]}}, w_half}
                                    : {16'h0, w_half};
            default: w_fmt = w_word;
        endcase
    end

    always_comb begin
        w_merge = w_word;
        case (r_size)
            2'b00: begin
                case (r_aluout[1:0])
                    2'd0:    w_merge[31:24] = r_wdata[7:0];
                    2'd1:    w_merge[23:16] = r_wdata[7:0];
                    2'd2:    w_merge[15:8]  = r_wdata[7:0];
                    default: w_merge[7:0]   = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_aluout[1]) w_merge[15:0]  = r_wdata[15:0];
                else             w_merge[31:16] = r_wdata[15:0];
            end
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_aluout   <= 32'h0;
            r_wdata    <= 32'h0;
            r_writereg <= 5'h0;
            r_cnt      <= 4'h0;
        end else if (!w_stall) begin
            r_regwrite <= RegWriteE;
            r_memtoreg <= MemtoRegE;
            r_memwrite <= MemWriteE;
            r_size     <= SizeE;
            r_signed   <= SignedE;
            r_aluout   <= ALUOutE;
            r_wdata    <= WriteDataE;
            r_writereg <= WriteRegE;
            r_cnt      <= (MemWriteE | MemtoRegE) ? LAT : 4'h0;
        end else begin
            r_cnt <= r_cnt - 4'h1;
        end
    end

    // Memory contents survive reset; a stalled store never reaches here
    // because reset clears r_memwrite first.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            unique case (1'b1)
                w_in_text:  r_text[w_tidx]  <= w_merge;
                w_in_data:  r_data[w_didx]  <= w_merge;
                w_in_stack: r_stack[w_sidx] <= w_merge;
                default: ;
            endcase
        end
    end

    assign RegWriteM = r_regwrite;
    assign MemtoRegM = r_memtoreg;
    assign ALUOutM   = r_aluout;
    assign WriteRegM = r_writereg;
    assign StallM    = w_stall;
    assign MemFaultM = w_fault;
    assign RD        = (r_memtoreg & ~w_fault) ? w_fmt : 32'h0;

endmodule

// File: tb/tb_mem_stage_ws.sv
// tb_mem_stage_ws: random + directed scoreboard bench for mem_stage_ws.
// Reference model keeps memory as an associative array of words.
module tb_mem_stage_ws;

    localparam int LAT = 2;

    typedef struct {
        bit          ld;
        bit          st;
        bit          rw;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [4:0]  wr;
        bit          lit_en;
        logic [31:0] lit;
    } op_t;

    typedef struct {
        op_t         op;
        bit          fault;
        bit          known;
        logic [31:0] rd;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteE = 1'b0;
    logic        MemtoRegE = 1'b0;
    logic        MemWriteE = 1'b0;
    logic [1:0]  SizeE = 2'b10;
    logic        SignedE = 1'b0;
    logic [31:0] ALUOutE = 32'h0;
    logic [31:0] WriteDataE = 32'h0;
    logic [4:0]  WriteRegE = 5'h0;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic [31:0] ALUOutM;
    logic [4:0]  WriteRegM;
    logic [31:0] RD;
    logic        StallM;
    logic        MemFaultM;

    mem_stage_ws #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .SizeE(SizeE), .SignedE(SignedE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RD(RD),
        .StallM(StallM), .MemFaultM(MemFaultM)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    bit drv_en = 1'b0;
    bit mon_en = 1'b0;
    int scnt = 0;
    op_t  stimq[$];
    exp_t scq[$];
    logic [31:0] mem [logic [31:0]];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mapped(logic [31:0] a);
        return (a < 32'h400) ||
               (a >= 32'h400 && a < 32'h1400) ||
               (a >= 32'h7FF000 && a <= 32'h7FFFFF);
    endfunction

    function automatic exp_t model(op_t op);
        exp_t e;
        logic [31:0] key, w, mask, v;
        int sh;
        bit mis;
        e.op = op;
        e.known = 1'b1;
        e.rd = 32'h0;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (op.sz == 2'b01 && op.a[0]) || (op.sz[1] && op.a[1:0] != 2'b00);
`endif
        e.fault = (op.ld || op.st) && (!mapped(op.a) || mis);
        e.stalls = (op.ld || op.st) ? LAT : 0;
        key = op.a & 32'hFFFF_FFFC;
        w = mem.exists(key) ? mem[key] : 32'h0;
        if (op.ld && !e.fault) begin
            e.known = mem.exists(key);
            if (op.sz == 2'b00) begin
                v = (w >> (8 * (3 - int'(op.a[1:0])))) & 32'hFF;
                if (op.sg && v[7]) v = v | 32'hFFFF_FF00;
            end else if (op.sz == 2'b01) begin
                v = (w >> (op.a[1] ? 0 : 16)) & 32'hFFFF;
                if (op.sg && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e.rd = v;
        end
        if (op.st && !e.fault) begin
            if (op.sz == 2'b00) begin
                sh = 8 * (3 - int'(op.a[1:0]));
                mask = 32'hFF << sh;
                mem[key] = (w & ~mask) | ((op.wd & 32'hFF) << sh);
            end else if (op.sz == 2'b01) begin
                sh = op.a[1] ? 0 : 16;
                mask = 32'hFFFF << sh;
                mem[key] = (w & ~mask) | ((op.wd & 32'hFFFF) << sh);
            end else begin
                mem[key] = op.wd;
            end
        end
        return e;
    endfunction

    function automatic op_t mk(bit ld, bit st, logic [1:0] sz, bit sg,
                               logic [31:0] a, logic [31:0] wd,
                               bit lit_en, logic [31:0] lit);
        op_t o;
        o.ld = ld; o.st = st; o.rw = ld; o.sz = sz; o.sg = sg;
        o.a = a; o.wd = wd; o.wr = 5'($urandom_range(1, 31));
        o.lit_en = lit_en; o.lit = lit;
        return o;
    endfunction

    task automatic drive(op_t o);
        RegWriteE  = o.rw;
        MemtoRegE  = o.ld;
        MemWriteE  = o.st;
        SizeE      = o.sz;
        SignedE    = o.sg;
        ALUOutE    = o.a;
        WriteDataE = o.wd;
        WriteRegE  = o.wr;
    endtask

    task automatic drive_nop();
        drive(mk(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h0));
        RegWriteE = 1'b0;
        WriteRegE = 5'h0;
    endtask

    // Driver: one op (or an idle nop) per free M slot, expectation pushed
    // on the capturing edge.
    initial forever begin
        op_t o;
        exp_t e;
        @(negedge clk);
        if (drv_en && rst_n && !StallM) begin
            if (stimq.size() != 0) begin
                o = stimq.pop_front();
            end else begin
                o = mk(0, 0, 2'($urandom_range(0, 3)), 0, $urandom, $urandom, 0, 32'h0);
                o.rw = 1'($urandom_range(0, 1));
            end
            drive(o);
            e = model(o);
            @(posedge clk);
            scq.push_back(e);
        end
    end

    // Monitor: the head of the scoreboard is always the op held in M.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!mon_en || !rst_n) begin
            scnt = 0;
        end else if (scq.size() != 0) begin
            e = scq[0];
            if (StallM) begin
                scnt++;
                chk("fault_hold", 32'(MemFaultM), 32'(e.fault));
            end else begin
                e = scq.pop_front();
                chk("stall_len", 32'(scnt), 32'(e.stalls));
                scnt = 0;
                chk("fault", 32'(MemFaultM), 32'(e.fault));
                chk("regwrite", 32'(RegWriteM), 32'(e.op.rw));
                chk("memtoreg", 32'(MemtoRegM), 32'(e.op.ld));
                chk("aluout", ALUOutM, e.op.a);
                chk("writereg", 32'(WriteRegM), 32'(e.op.wr));
                if (!(e.op.ld && e.fault) && e.known)
                    chk("rd", RD, e.rd);
                if (e.op.lit_en)
                    chk("rd_lit", RD, e.op.lit);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (stimq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(stimq.size()), 32'h0);
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        nerr++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    logic [31:0] pool [11];
    logic [31:0] pa;

    initial begin
        pool = '{32'h0, 32'h3FC, 32'h400, 32'h404, 32'h13FC, 32'h7FF000,
                 32'h7FFBFC, 32'h7FFFFC, 32'h1400, 32'h7FEFFC, 32'h800000};
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(StallM), 32'h0);
        chk("rst_fault", 32'(MemFaultM), 32'h0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_alu", ALUOutM, 32'h0);
        chk("rst_ctl", {27'h0, RegWriteM, MemtoRegM, 3'h0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        drv_en = 1'b1;

        stimq.push_back(mk(0, 1, 2'b10, 0, 32'h400, 32'h1, 0, 0));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h400, 0, 1, 32'h1));
        stimq.push_back(mk(0, 1, 2'b10, 0, 32'h7FFBFC, 32'h11223344, 0, 0));
        stimq.push_back(mk(0, 1, 2'b00, 0, 32'h7FFBFD, 32'hAA, 0, 0));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h7FFBFC, 0, 1, 32'h11AA3344));
        stimq.push_back(mk(1, 0, 2'b00, 1, 32'h7FFBFD, 0, 1, 32'hFFFFFFAA));
        stimq.push_back(mk(1, 0, 2'b00, 0, 32'h7FFBFD, 0, 1, 32'h000000AA));
        stimq.push_back(mk(1, 0, 2'b01, 1, 32'h7FFBFC, 0, 1, 32'h000011AA));
        stimq.push_back(mk(0, 1, 2'b10, 0, 32'h0, 32'h12345678, 0, 0));
        stimq.push_back(mk(0, 1, 2'b10, 0, 32'h800000, 32'hDEAD, 0, 0));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h800000, 0, 0, 0));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h0, 0, 1, 32'h12345678));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h400, 0, 1, 32'h1));
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h7FFBFC, 0, 1, 32'h11AA3344));
`ifdef MEM_ALIGN_CHECK_EN
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h401, 0, 0, 0));
`else
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h401, 0, 1, 32'h1));
`endif
        drain();

        foreach (pool[i]) stimq.push_back(mk(0, 1, 2'b10, 0, pool[i], $urandom, 0, 0));
        foreach (pool[i]) stimq.push_back(mk(1, 0, 2'b10, 0, pool[i], 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            pa = pool[$urandom_range(0, 10)] + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: stimq.push_back(mk(1, 0, 2'($urandom_range(0, 3)),
                                      1'($urandom_range(0, 1)), pa, 0, 0, 0));
                1: stimq.push_back(mk(0, 1, 2'($urandom_range(0, 3)), 0, pa,
                                      $urandom, 0, 0));
                default: stimq.push_back(mk(0, 0, 2'b10, 0, pa, $urandom, 0, 0));
            endcase
        end
        drain();

        // Reset in the second stall cycle of a store to 0x0.
        stimq.push_back(mk(0, 1, 2'b10, 0, 32'h0, 32'h12345678, 0, 0));
        drain();
        @(posedge clk);
        drv_en = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        drive_nop();
        repeat (LAT + 2) @(negedge clk);
        drive(mk(0, 1, 2'b10, 0, 32'h0, 32'h5, 0, 0));
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_stall", 32'(StallM), 32'h1);
        drive_nop();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(StallM), 32'h0);
        chk("midrst_alu", ALUOutM, 32'h0);
        chk("midrst_ctl", {27'h0, RegWriteM, MemtoRegM, 3'h0}, 32'h0);
        chk("midrst_wreg", 32'(WriteRegM), 32'h0);
        chk("midrst_fault", 32'(MemFaultM), 32'h0);
        chk("midrst_rd", RD, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scq.delete();
        @(negedge clk);
        mon_en = 1'b1;
        drv_en = 1'b1;
        stimq.push_back(mk(1, 0, 2'b10, 0, 32'h0, 0, 1, 32'h12345678));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
